// File: rtl/huffman_table_loader_pkg.sv
// Shared definitions for the canonical Huffman table loader: log2 helper and FSM state encoding.
package huffman_table_loader_pkg;

    localparam int unsigned DEF_WIDTH_OUT       = 8;
    localparam int unsigned DEF_MAX_CODE_LENGTH = 9;

    // Ceiling log2; used to size code-length fields.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) r++;
        return r;
    endfunction

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_e;

endpackage

// File: rtl/huffman_table_loader_if.sv
// Entry stream in, decoder table-write port out.
interface huffman_table_loader_if
    import huffman_table_loader_pkg::*;
#(
    parameter int unsigned WIDTH_OUT            = DEF_WIDTH_OUT,
    parameter int unsigned MAX_CODE_LENGTH      = DEF_MAX_CODE_LENGTH,
    parameter int unsigned LOG2_MAX_CODE_LENGTH = clog2(MAX_CODE_LENGTH)
);
    logic                            in_valid;
    logic                            in_ready;
    logic [WIDTH_OUT-1:0]            in_symbol;
    logic [LOG2_MAX_CODE_LENGTH-1:0] in_length;
    logic                            in_last;

    logic                            table_push;
    logic [MAX_CODE_LENGTH-1:0]      table_addr;
    logic [LOG2_MAX_CODE_LENGTH-1:0] table_code_width;
    logic [WIDTH_OUT-1:0]            table_data;

    // Upstream entry source and table consumer side.
    modport master (
        output in_valid, in_symbol, in_length, in_last,
        input  in_ready, table_push, table_addr, table_code_width, table_data
    );

    // Loader side.
    modport slave (
        input  in_valid, in_symbol, in_length, in_last,
        output in_ready, table_push, table_addr, table_code_width, table_data
    );
endinterface

// File: rtl/huffman_table_loader.sv
// Assigns canonical Huffman codes to a sorted (symbol, length) stream and writes
// every replicated lookup-table entry, one write per cycle.
module huffman_table_loader
    import huffman_table_loader_pkg::*;
#(
    parameter int unsigned WIDTH_OUT            = DEF_WIDTH_OUT,
    parameter int unsigned MAX_CODE_LENGTH      = DEF_MAX_CODE_LENGTH,
    parameter int unsigned LOG2_MAX_CODE_LENGTH = clog2(MAX_CODE_LENGTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    huffman_table_loader_if.slave   bus,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic                    incomplete
);
    localparam int unsigned AW = MAX_CODE_LENGTH;
    localparam int unsigned CW = MAX_CODE_LENGTH + 1;
    localparam int unsigned LW = LOG2_MAX_CODE_LENGTH;
    localparam int unsigned DW = WIDTH_OUT;

    state_e         state_q, state_d;
    logic [CW-1:0]  code_q, code_d;
    logic [CW-1:0]  nc_q, nc_d;
    logic [LW-1:0]  prev_len_q, prev_len_d;
    logic           last_q, last_d;
    logic [AW-1:0]  base_q, base_d;
    logic [AW-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]  rep_max_q, rep_max_d;

    logic           in_ready_q, in_ready_d;
    logic           table_push_q, table_push_d;
    logic [AW-1:0]  table_addr_q, table_addr_d;
    logic [LW-1:0]  table_code_width_q, table_code_width_d;
    logic [DW-1:0]  table_data_q, table_data_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           error_q, error_d;
    logic           incomplete_q, incomplete_d;

    // Canonical-code arithmetic for the entry currently offered.
    logic [LW-1:0]  shift_c;
    logic [LW-1:0]  rem_c;
    logic [CW-1:0]  nc_c;
    logic [CW-1:0]  limit_c;
    logic           len_bad_c;
    logic           accept_c;

    always_comb begin
        shift_c   = bus.in_length - prev_len_q;
        rem_c     = LW'(MAX_CODE_LENGTH) - bus.in_length;
        nc_c      = code_q << shift_c;
        limit_c   = CW'(1) << bus.in_length;
        len_bad_c = (bus.in_length == '0)
                 || (32'(bus.in_length) > MAX_CODE_LENGTH)
                 || (bus.in_length < prev_len_q);
        accept_c  = bus.in_valid && in_ready_q;
    end

    always_comb begin
        state_d            = state_q;
        code_d             = code_q;
        nc_d               = nc_q;
        prev_len_d         = prev_len_q;
        last_d             = last_q;
        base_d             = base_q;
        cnt_d              = cnt_q;
        rep_max_d          = rep_max_q;
        table_push_d       = 1'b0;
        table_addr_d       = table_addr_q;
        table_code_width_d = table_code_width_q;
        table_data_d       = table_data_q;
        done_d             = done_q;
        error_d            = error_q;
        incomplete_d       = incomplete_q;

        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d      = LOAD;
                    code_d       = '0;
                    prev_len_d   = '0;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    incomplete_d = 1'b0;
                end
            end
            LOAD: begin
                if (accept_c) begin
                    if (len_bad_c || (nc_c >= limit_c)) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end else begin
                        // First replica is presented the cycle right after the accept.
                        state_d            = WRITE;
                        nc_d               = nc_c;
                        base_d             = AW'(nc_c << rem_c);
                        rep_max_d          = AW'((CW'(1) << rem_c) - CW'(1));
                        cnt_d              = '0;
                        last_d             = bus.in_last;
                        table_push_d       = 1'b1;
                        table_addr_d       = AW'(nc_c << rem_c);
                        table_code_width_d = bus.in_length;
                        table_data_d       = bus.in_symbol;
                    end
                end
            end
            WRITE: begin
                if (cnt_q == rep_max_q) begin
                    code_d     = nc_q + CW'(1);
                    prev_len_d = table_code_width_q;
                    if (last_q) begin
                        state_d      = DONE;
                        done_d       = 1'b1;
                        incomplete_d = (nc_q + CW'(1)) != (CW'(1) << table_code_width_q);
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    cnt_d        = cnt_q + AW'(1);
                    table_push_d = 1'b1;
                    table_addr_d = base_q | (cnt_q + AW'(1));
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == LOAD);
        busy_d     = (state_d == LOAD) || (state_d == WRITE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= IDLE;
            code_q             <= '0;
            nc_q               <= '0;
            prev_len_q         <= '0;
            last_q             <= 1'b0;
            base_q             <= '0;
            cnt_q              <= '0;
            rep_max_q          <= '0;
            in_ready_q         <= 1'b0;
            table_push_q       <= 1'b0;
            table_addr_q       <= '0;
            table_code_width_q <= '0;
            table_data_q       <= '0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            error_q            <= 1'b0;
            incomplete_q       <= 1'b0;
        end else begin
            state_q            <= state_d;
            code_q             <= code_d;
            nc_q               <= nc_d;
            prev_len_q         <= prev_len_d;
            last_q             <= last_d;
            base_q             <= base_d;
            cnt_q              <= cnt_d;
            rep_max_q          <= rep_max_d;
            in_ready_q         <= in_ready_d;
            table_push_q       <= table_push_d;
            table_addr_q       <= table_addr_d;
            table_code_width_q <= table_code_width_d;
            table_data_q       <= table_data_d;
            busy_q             <= busy_d;
            done_q             <= done_d;
            error_q            <= error_d;
            incomplete_q       <= incomplete_d;
        end
    end

    assign bus.in_ready         = in_ready_q;
    assign bus.table_push       = table_push_q;
    assign bus.table_addr       = table_addr_q;
    assign bus.table_code_width = table_code_width_q;
    assign bus.table_data       = table_data_q;
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign error                = error_q;
    assign incomplete           = incomplete_q;

endmodule

// File: doc/huffman_table_loader.md
Name: huffman_table_loader

Overview:
- Upstream companion of the stream decoder. Drives that decoder's table write port: table_push, table_addr, table_code_width, table_data.
- Accepts a canonical Huffman code description as a stream of (symbol, code length) entries, pre-sorted by length and then by symbol.
- Assigns canonical codes and writes every replicated entry of the 2^MAX_CODE_LENGTH lookup table, one write per cycle.
- Reports completion, malformed input and incomplete code sets.

Parameters:
- WIDTH_OUT, 8, symbol width; matches the decoder's table_data.
- MAX_CODE_LENGTH, 9, longest code in bits; the table has 2^MAX_CODE_LENGTH entries.
- LOG2_MAX_CODE_LENGTH, log2(MAX_CODE_LENGTH) (shared log2 function, ceiling), width of code-length fields.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a new table load; honoured in IDLE, DONE and ERROR only.
- in_valid  in  1  entry present.
- in_ready  out  1  entry accepted when in_valid && in_ready.
- in_symbol  in  WIDTH_OUT  decoded symbol value.
- in_length  in  LOG2_MAX_CODE_LENGTH  code length; legal range 1..MAX_CODE_LENGTH.
- in_last  in  1  final entry of this table.
- table_push  out  1  table write strobe.
- table_addr  out  MAX_CODE_LENGTH  table write address.
- table_code_width  out  LOG2_MAX_CODE_LENGTH  code length written.
- table_data  out  WIDTH_OUT  symbol written.
- busy  out  1  high in LOAD and WRITE.
- done  out  1  load finished cleanly; held until start or rst.
- error  out  1  malformed input; held until start or rst.
- incomplete  out  1  valid with done; the code space is not fully used.

Behaviour:
- Reset values: all outputs 0; state IDLE; code register 0; prev_len 0.
- Clock and reset: one clock (clk); synchronous active-high reset (rst). rst has priority in every state. A reset mid-WRITE drops table_push on the next edge and aborts the load. Table entries already written stay stale and are the decoder's concern.
- Bit order: code bits occupy the MSBs of the MAX_CODE_LENGTH lookup window, MSB first. A code c of length L maps to addresses c<<(MAX-L) through c<<(MAX-L) + 2^(MAX-L) - 1.
- States:
  - IDLE: start -> LOAD; clears code, prev_len, done, error and incomplete.
  - LOAD: in_ready=1. On accept, with L = in_length:
    - L==0, L>MAX or L<prev_len -> ERROR.
    - Otherwise nc = code << (L - prev_len), computed in MAX_CODE_LENGTH+1 bits. If nc >= 2^L (over-subscribed) -> ERROR.
    - Otherwise: latch base = nc<<(MAX-L), symbol, L and last; replica counter = 0; -> WRITE.
  - WRITE: in_ready=0. Each cycle: table_push=1, table_addr = base | counter, counter++. After replica 2^(MAX-L)-1:
    - code = nc+1 and prev_len = L.
    - If last -> DONE; else -> LOAD.
  - DONE: done=1. incomplete = (code != 2^prev_len), evaluated in MAX+1 bits. start -> LOAD, with the same clears as IDLE.
  - ERROR: error=1; no table writes. start -> LOAD, with the same clears.
- Timing:
  - Table outputs are registered. An entry accepted on edge t gives its first table_push in the cycle after t.
  - Each entry costs 1 accept cycle plus 2^(MAX-L) write cycles.
  - done rises the cycle after the final write.
- Erroring entries produce no table_push.
- start while busy is ignored.
- in_valid outside LOAD is ignored; no entry is consumed.
- Equal lengths (L == prev_len) give shift 0, i.e. consecutive codes.

Decomposition:
- Shared package/include:
  - the log2 function (the existing common include);
  - state encoding constants IDLE, LOAD, WRITE, DONE, ERROR.
- Single module, no sub-modules. The canonical-code arithmetic is a few lines of combinational logic feeding the FSM registers.

Test Plan:
- Defaults. Entries (0x41,L1), (0x42,L2), (0x43,L2,last):
  - required pushes, in order: addr 0..255 data 0x41 width 1; addr 256..383 data 0x42 width 2; addr 384..511 data 0x43 width 2;
  - 515 cycles from first accept to last write; done=1, incomplete=0, error=0.
- Entries (0x01,L1), (0x02,L1), (0x03,L1): third accept -> error=1, no push for 0x03, done=0.
- Entries (0x05,L2), (0x06,L1) -> error=1 after the second accept; only addr 0..127 written.
- Single entry (0x7F,L9,last) -> exactly one push at addr 0 width 9; done=1, incomplete=1.
- Entry with L0, or with L10 on a 4-bit field -> immediate error, zero pushes.
- Reset mid-load: rst asserted during the 50th replica of a L1 entry -> table_push=0 the next cycle; all outputs 0, state IDLE. A subsequent start plus the first scenario reproduces identical writes.
